fifo_burst_rd: RTL
==================

FIFO_BURST_RD -- requirements
Module: fifo_burst_rd

Interface
REQ-001 SHALL provide parameter W, default 8: data width; it matches the FIFO rd_data width.
REQ-002 SHALL provide parameter DP, default 16: FIFO depth, a power of two from 2 to 256.
REQ-003 SHALL provide parameter AW, derived as log2(DP): FIFO address width; count ports are AW+1 bits.
REQ-004 SHALL have rd_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have rd_reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have fifo_empty, input, 1: FIFO empty flag, in the rd_clk domain.
REQ-007 SHALL have fifo_rd_aval, input, AW+1: number of words readable in the FIFO.
REQ-008 SHALL have fifo_rd_data, input, W: show-ahead FIFO head word; it is valid whenever fifo_empty=0.
REQ-009 SHALL have fifo_rd_en, output, 1: FIFO pop strobe, one word per cycle.
REQ-010 SHALL have cfg_burst_len, input, AW+1: beats per burst; 0 disables the block.
REQ-011 SHALL have cfg_timeout, input, 8: idle cycles before a short burst (used only with the macro of REQ-030).
REQ-012 SHALL have m_valid, m_data[W-1:0], m_last, output: downstream beat, its data and the final-beat flag.
REQ-013 SHALL have m_ready, input, 1: downstream accept.
REQ-014 SHALL have busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, BURST and DONE.
REQ-016 IDLE to BURST SHALL occur when cfg_burst_len!=0 and fifo_rd_aval>=cfg_burst_len.
- On that transition, cfg_burst_len is latched into beats_left (AW+1 bits).
REQ-017 SHALL treat cfg_burst_len>DP as DP, clamped at latch time.
REQ-018 SHALL ignore any change to cfg_burst_len or cfg_timeout after latch until the next IDLE.
REQ-019 SHALL drive fifo_rd_en = (state==BURST) && beats_left!=0 && !fifo_empty && (!m_valid || m_ready), combinationally.
REQ-020 On fifo_rd_en, SHALL register the beat on the next edge:
- m_data <= fifo_rd_data, m_valid <= 1, m_last <= (beats_left==1), beats_left decrements.
- Latency from pop to m_valid is 1 cycle; full throughput is 1 beat per cycle while m_ready=1.
REQ-021 While m_valid=1 and m_ready=0, SHALL hold m_data and m_last stable and keep fifo_rd_en=0.
REQ-022 On m_valid && m_ready without a new pop in the same cycle, SHALL clear m_valid the next cycle.
REQ-023 SHALL go BURST to DONE when the last beat is popped (beats_left 1 to 0).
REQ-024 SHALL go DONE to IDLE on m_valid && m_ready && m_last.
- IDLE re-evaluates REQ-016 on the following cycle; there is no back-to-back burst start in DONE.
REQ-025 If fifo_empty=1 during BURST, SHALL stall with no pop and no error, and resume when data arrives.
REQ-026 SHALL never assert fifo_rd_en when fifo_empty=1, in any state.

Reset
REQ-027 With rd_reset=1 at a rising edge, SHALL set state=IDLE, beats_left=0, m_valid=0, m_last=0, m_data=0, and clear the timeout counter.
REQ-028 SHALL hold fifo_rd_en=0 and busy=0 while rd_reset=1.
REQ-029 Reset mid-burst SHALL abandon the burst.
- A beat held in the output register is dropped.
- Words still in the FIFO are not touched.

Configuration
REQ-030 SHALL use the macro FIFO_BURST_RD_TIMEOUT_EN to control the short-burst timeout.
- Defined: an 8-bit counter counts cycles in IDLE while 0<fifo_rd_aval<cfg_burst_len and cfg_timeout!=0.
- When the count reaches cfg_timeout, the block enters BURST with beats_left=fifo_rd_aval.
- The counter clears on leaving IDLE or when fifo_rd_aval=0.
- Not defined: the counter is absent, cfg_timeout is ignored, and only REQ-016 starts bursts.

Verification
REQ-031 cfg_burst_len=4, FIFO preloaded with A0..A3, m_ready=1 -> fifo_rd_en high for 4 consecutive cycles; m_valid for 4 cycles with data A0..A3; m_last only on A3; busy falls 1 cycle after the A3 handshake.
REQ-032 cfg_burst_len=4, 3 words, macro off -> no fifo_rd_en ever; a 4th word arrives -> burst starts the next cycle.
REQ-033 cfg_burst_len=4, m_ready toggled 1,0,0,1,... -> m_data stable while stalled; exactly 4 pops; no duplicated or lost beats.
REQ-034 Macro on, cfg_timeout=10, 2 words, cfg_burst_len=8 -> IDLE for 10 cycles, then a 2-beat burst with m_last on beat 2.
REQ-035 rd_reset asserted while beats_left=2 with m_valid=1 -> next cycle m_valid=0, busy=0; 2 words remain in the FIFO; a new burst needs the full threshold again.
REQ-036 cfg_burst_len=20, DP=16, FIFO full -> exactly 16 beats; m_last on beat 16.

Source files
------------

// File: rtl/fifo_burst_rd.sv
// fifo_burst_rd: pulls fixed-length bursts from a show-ahead FIFO and replays
// them on a valid/ready stream. Output is one register stage (pop -> m_valid
// is one cycle) and sustains one beat per cycle while m_ready is held high.
// Optional build macro FIFO_BURST_RD_TIMEOUT_EN: when defined, a short burst
// of whatever is in the FIFO is flushed after cfg_timeout idle cycles.
module fifo_burst_rd #(
  parameter int W  = 8,
  parameter int DP = 16,
  parameter int AW = $clog2(DP)
) (
  input  logic          rd_clk,
  input  logic          rd_reset,
  input  logic          fifo_empty,
  input  logic [AW:0]   fifo_rd_aval,
  input  logic [W-1:0]  fifo_rd_data,
  output logic          fifo_rd_en,
  input  logic [AW:0]   cfg_burst_len,
  input  logic [7:0]    cfg_timeout,
  output logic          m_valid,
  output logic [W-1:0]  m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam logic [AW:0] DP_W  = (AW+1)'(DP);
  localparam logic [AW:0] ONE_W = (AW+1)'(1);

  state_t         state_q, state_d;
  logic [AW:0]    beats_q, beats_d;
  logic           mv_q, mv_d;
  logic           ml_q, ml_d;
  logic [W-1:0]   md_q, md_d;
  logic [AW:0]    len_clamp;
  logic           pop;

`ifdef FIFO_BURST_RD_TIMEOUT_EN
  logic [7:0]     tmo_q, tmo_d;
`else
  // cfg_timeout has no function without the timeout feature
  logic           unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
`endif

  // Oversized burst requests are capped at the FIFO depth, so a full FIFO
  // always satisfies the start threshold.
  assign len_clamp = (cfg_burst_len > DP_W) ? DP_W : cfg_burst_len;

  // Pop only when the output register is free or being drained this cycle.
  assign pop = (state_q == BURST) && (beats_q != '0) && !fifo_empty &&
               (!mv_q || m_ready) && !rd_reset;

  assign fifo_rd_en = pop;
  assign busy       = (state_q != IDLE) && !rd_reset;
  assign m_valid    = mv_q;
  assign m_data     = md_q;
  assign m_last     = ml_q;

  // Next-state, burst counter and output register update
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    mv_d    = mv_q;
    ml_d    = ml_q;
    md_d    = md_q;
`ifdef FIFO_BURST_RD_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (len_clamp != '0 && fifo_rd_aval >= len_clamp) begin
          state_d = BURST;
          beats_d = len_clamp;
        end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        else if (len_clamp != '0 && fifo_rd_aval != '0 && cfg_timeout != 8'd0 &&
                 tmo_q == cfg_timeout - 8'd1) begin
          state_d = BURST;
          beats_d = fifo_rd_aval;
        end
`endif
      end
      BURST: if (pop && beats_q == ONE_W) state_d = DONE;
      DONE:  if (mv_q && m_ready && ml_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      mv_d    = 1'b1;
      md_d    = fifo_rd_data;
      ml_d    = (beats_q == ONE_W);
      beats_d = beats_q - ONE_W;
    end else if (mv_q && m_ready) begin
      mv_d = 1'b0;
    end

`ifdef FIFO_BURST_RD_TIMEOUT_EN
    // Count idle cycles only while a partial burst is waiting
    if (state_q != IDLE || state_d != IDLE || fifo_rd_aval == '0)
      tmo_d = 8'd0;
    else if (len_clamp != '0 && cfg_timeout != 8'd0)
      tmo_d = tmo_q + 8'd1;
`endif
  end

  // State registers with synchronous reset; reset drops any held beat
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state_q <= IDLE;
      beats_q <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
`ifdef FIFO_BURST_RD_TIMEOUT_EN
      tmo_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      md_q    <= md_d;
`ifdef FIFO_BURST_RD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule
